// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and default widths.
package pc_sequencer_pkg;

   localparam int unsigned PC_W_DEF  = 10;
   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned BOFF_W    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Start/Done handshake plus the ALU/decoder branch and reset signals seen by the sequencer.
interface pc_sequencer_if
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic              start;
   logic [PC_W-1:0]   start_addr;
   logic              branch;
   logic [BOFF_W-1:0] boffset;
   logic              bsign;
   logic              alu_reset;
   logic              alu_halt;
   logic [PC_W-1:0]   pc;
   logic              running;
   logic              done;
   logic [CNT_W-1:0]  cycle_count;

   modport master (
      output start, start_addr, branch, boffset, bsign, alu_reset, alu_halt,
      input  pc, running, done, cycle_count
   );

   modport slave (
      input  start, start_addr, branch, boffset, bsign, alu_reset, alu_halt,
      output pc, running, done, cycle_count
   );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection while running: halt-hold, soft restart, branch or increment.
module pc_next_calc
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0]   pc,
   input  logic [PC_W-1:0]   restart_addr,
   input  logic              branch,
   input  logic [BOFF_W-1:0] boffset,
   input  logic              bsign,
   input  logic              alu_reset,
   input  logic              alu_halt,
   output logic [PC_W-1:0]   pc_nxt_c
);

   logic [PC_W-1:0] off_ext;

   assign off_ext = PC_W'(boffset);

   // Arithmetic wraps modulo 2^PC_W in both directions by construction.
   always_comb begin
      pc_nxt_c = pc + PC_W'(1);
      if (alu_reset) begin
         pc_nxt_c = alu_halt ? pc : restart_addr;
      end else if (branch) begin
         pc_nxt_c = bsign ? (pc - off_ext) : (pc + off_ext);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, state and latched start address.
// Optional executed-cycle counter is built when CYCLE_COUNT_EN is defined.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic     clk,
   input  logic     rst,
   pc_sequencer_if.slave bus
);

   pc_state_t       state;
   pc_state_t       state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] pc_calc_c;
   logic [PC_W-1:0] base_addr;
   logic            start_acc;

   pc_next_calc #(.PC_W(PC_W)) u_next_calc (
      .pc           (bus.pc),
      .restart_addr (base_addr),
      .branch       (bus.branch),
      .boffset      (bus.boffset),
      .bsign        (bus.bsign),
      .alu_reset    (bus.alu_reset),
      .alu_halt     (bus.alu_halt),
      .pc_nxt_c     (pc_calc_c)
   );

   // Next state and next PC; ALU/decoder inputs only matter in RUN.
   always_comb begin
      state_nxt = state;
      pc_nxt    = bus.pc;
      start_acc = 1'b0;
      case (state)
         IDLE, HALTED: begin
            if (bus.start) begin
               start_acc = 1'b1;
               state_nxt = RUN;
               pc_nxt    = bus.start_addr;
            end
         end
         RUN: begin
            pc_nxt = pc_calc_c;
            if (bus.alu_reset && bus.alu_halt) begin
               state_nxt = HALTED;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bus.pc      <= '0;
         bus.running <= 1'b0;
         bus.done    <= 1'b0;
         base_addr   <= '0;
      end else begin
         state       <= state_nxt;
         bus.pc      <= pc_nxt;
         bus.running <= (state_nxt == RUN);
         bus.done    <= (state_nxt == HALTED);
         if (start_acc) begin
            base_addr <= bus.start_addr;
         end
      end
   end

`ifdef CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt;

   // Counts every edge taken in RUN, including the halting one; saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start_acc) begin
         cnt <= '0;
      end else if ((state == RUN) && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.cycle_count = cnt;
`else
   assign bus.cycle_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

   localparam int PC_MOD  = 1024;
   localparam int CNT_MAX = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pc_sequencer_if bus ();

   pc_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Behavioural model: 0 idle, 1 running, 2 halted.
   int mstate = 0;
   int mpc    = 0;
   int mbase  = 0;
   int mruns  = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic int exp_count();
`ifdef CYCLE_COUNT_EN
      return (mruns > CNT_MAX) ? CNT_MAX : mruns;
`else
      return 0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mstate = 0; mpc = 0; mbase = 0; mruns = 0;
      end else if (mstate != 1) begin
         if (bus.start) begin
            mstate = 1;
            mpc    = int'(bus.start_addr);
            mbase  = int'(bus.start_addr);
            mruns  = 0;
         end
      end else begin
         mruns++;
         if (bus.alu_reset && bus.alu_halt) mstate = 2;
         else if (bus.alu_reset)            mpc = mbase;
         else if (bus.branch && bus.bsign)  mpc = ((mpc - int'(bus.boffset)) % PC_MOD + PC_MOD) % PC_MOD;
         else if (bus.branch)               mpc = (mpc + int'(bus.boffset)) % PC_MOD;
         else                               mpc = (mpc + 1) % PC_MOD;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("pc",          int'(bus.pc),          mpc);
      chk("running",     int'(bus.running),     (mstate == 1) ? 1 : 0);
      chk("done",        int'(bus.done),        (mstate == 2) ? 1 : 0);
      chk("cycle_count", int'(bus.cycle_count), exp_count());
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.branch = 1'b0; bus.boffset = 4'd0; bus.bsign = 1'b0;
      bus.alu_reset = 1'b0; bus.alu_halt = 1'b0;
   endtask

   // Halt if needed, then start a program at addr.
   task automatic go(input logic [9:0] addr);
      idle_inputs();
      if (mstate == 1) begin
         bus.alu_reset = 1'b1; bus.alu_halt = 1'b1;
         tick(1);
         idle_inputs();
      end
      bus.start = 1'b1; bus.start_addr = addr;
      tick(1);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      bus.start_addr = '0;
      #3;
      chk("reset_pc", int'(bus.pc), 0);
      chk("reset_running", int'(bus.running), 0);
      chk("reset_done", int'(bus.done), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Sequential run from 0.
      go(10'h000);
      chk("seq_pc0", int'(bus.pc), 0);
      for (int i = 1; i <= 5; i++) begin
         tick(1);
         chk("seq_pc", int'(bus.pc), i);
         chk("seq_running", int'(bus.running), 1);
      end

      // Forward, backward and wrapping branches.
      go(10'h020);
      bus.branch = 1'b1; bus.boffset = 4'd7; bus.bsign = 1'b0;
      tick(1);
      chk("br_fwd", int'(bus.pc), 'h027);
      go(10'h020);
      bus.branch = 1'b1; bus.boffset = 4'd7; bus.bsign = 1'b1;
      tick(1);
      chk("br_back", int'(bus.pc), 'h019);
      go(10'h002);
      bus.branch = 1'b1; bus.boffset = 4'd5; bus.bsign = 1'b1;
      tick(1);
      chk("br_wrap", int'(bus.pc), 'h3FD);
      go(10'h3FF);
      tick(1);
      chk("inc_wrap", int'(bus.pc), 'h000);
      go(10'h030);
      bus.branch = 1'b1; bus.boffset = 4'd0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("self_loop", int'(bus.pc), 'h030);
         chk("self_loop_run", int'(bus.running), 1);
      end

      // Soft restart then halt with a simultaneous (ignored) Start.
      go(10'h100);
      tick(8);
      chk("pre_restart", int'(bus.pc), 'h108);
      bus.alu_reset = 1'b1;
      tick(1);
      idle_inputs();
      chk("soft_restart", int'(bus.pc), 'h100);
      chk("soft_running", int'(bus.running), 1);
      tick(4);
      bus.alu_reset = 1'b1; bus.alu_halt = 1'b1;
      bus.start = 1'b1; bus.start_addr = 10'h200;
      tick(1);
      idle_inputs();
      chk("halt_done", int'(bus.done), 1);
      chk("halt_running", int'(bus.running), 0);
      chk("halt_pc", int'(bus.pc), 'h104);
      tick(2);
      chk("halt_hold_done", int'(bus.done), 1);
      chk("halt_hold_pc", int'(bus.pc), 'h104);

      // Cycle counter: halt on the 9th RUN edge.
      go(10'h000);
      tick(8);
      bus.alu_reset = 1'b1; bus.alu_halt = 1'b1;
      tick(1);
      idle_inputs();
`ifdef CYCLE_COUNT_EN
      chk("count_halt", int'(bus.cycle_count), 9);
      tick(2);
      chk("count_hold", int'(bus.cycle_count), 9);
`else
      chk("count_halt", int'(bus.cycle_count), 0);
      tick(2);
      chk("count_hold", int'(bus.cycle_count), 0);
`endif
      go(10'h000);
      chk("count_clear", int'(bus.cycle_count), 0);

      // Asynchronous reset mid-RUN.
      go(10'h050);
      tick(10);
      chk("pre_reset_pc", int'(bus.pc), 'h05A);
      #2 rst = 1'b1;
      #1;
      chk("async_pc", int'(bus.pc), 0);
      chk("async_running", int'(bus.running), 0);
      chk("async_done", int'(bus.done), 0);
      @(posedge clk); #1 rst = 1'b0;
      bus.start = 1'b1; bus.start_addr = 10'h010;
      tick(1);
      idle_inputs();
      chk("post_reset_pc", int'(bus.pc), 'h010);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         bus.start      = ($urandom_range(0, 9) == 0);
         bus.start_addr = 10'($urandom);
         bus.branch     = ($urandom_range(0, 9) < 4);
         bus.boffset    = 4'($urandom);
         bus.bsign      = 1'($urandom);
         bus.alu_reset  = ($urandom_range(0, 29) == 0);
         bus.alu_halt   = 1'($urandom);
         if ($urandom_range(0, 199) == 0) rst = 1'b1;
         tick(1);
         rst = 1'b0;
      end

      idle_inputs();
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle core. It owns the PC register, steps it once per clock while a program runs, applies the signed branch offset and sign produced by the ALU's branch op, and acts on the ALU's reset/halt requests. It exposes a Start/Done handshake to the testbench or top level, and optionally counts executed cycles.

## Interface
Parameters:
- PC_W, 10: PC width in bits; the instruction ROM holds 2^PC_W words.
- CNT_W, 16: cycle counter width; used only when the counter is compiled in.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; forces all state to its reset values.
- Start  in  1  single-cycle request to begin a program.
- StartAddr  in  PC_W  first instruction address, sampled when Start is accepted.
- Branch  in  1  from the decoder: the instruction at PC is a branch (kBRC).
- bOFFSET  in  4  branch magnitude from the ALU.
- bSIGN  in  1  branch direction from the ALU; 1 means backward.
- AluReset  in  1  the ALU reset request (kRST).
- AluHalt  in  1  the ALU halt qualifier (kRST with toggle set).
- PC  out  PC_W  current instruction address (registered).
- Running  out  1  high while the state is RUN.
- Done  out  1  high while the state is HALTED.
- CycleCount  out  CNT_W  number of RUN cycles since the last accepted Start.

## Operation
- States: IDLE, RUN and HALTED, encoded in the shared package as pc_state_t.
- Reset values: state IDLE, PC 0, Running 0, Done 0, CycleCount 0.
- IDLE or HALTED with Start=1: PC <= StartAddr, state <= RUN, Done <= 0, CycleCount <= 0.
- Start while in RUN is ignored.
- In RUN, the next PC is chosen in priority order:
  - AluReset=1 and AluHalt=1: PC holds; state <= HALTED.
  - AluReset=1 and AluHalt=0: soft restart; PC <= StartAddr as latched at the last Start; state stays RUN.
  - Branch=1 and bSIGN=0: PC <= PC + bOFFSET.
  - Branch=1 and bSIGN=1: PC <= PC - bOFFSET.
  - Otherwise: PC <= PC + 1.
- Branch arithmetic is unsigned modulo 2^PC_W and wraps silently in both directions. bOFFSET is zero-extended to PC_W before use.
- bOFFSET=0 with Branch=1 leaves PC unchanged (self-loop); this is legal and is not a halt.
- A not-taken branch arrives as offset 1, sign 0, so it advances by 1 with no special case.
- Sequential PC+1 at address 2^PC_W-1 wraps to 0.
- Branch, bOFFSET, bSIGN, AluReset and AluHalt are ignored outside RUN.
- Running and Done are decoded from registered state and are never high together.

## Timing
- Everything the ALU and decoder produce for the instruction at PC is combinational within the cycle; the sequencer samples it on the next rising edge. Effective latency is one cycle per instruction.
- Start accepted at edge N: PC=StartAddr and Running=1 after edge N. The instruction at StartAddr executes in cycle N+1.
- Halt seen at edge N: Done=1 and Running=0 after edge N. PC keeps the address of the halting instruction.
- Done stays high until a Start is accepted; Start and Done may be high in the same cycle.
- Reset asserted mid-RUN clears everything immediately, without waiting for a clock edge. The program restarts only after a fresh Start.

## Configuration
- CYCLE_COUNT_EN defined:
  - CycleCount increments by 1 on every edge taken in RUN, including the halting edge.
  - It saturates at 2^CNT_W-1, is cleared by an accepted Start and by Reset, and holds its value in HALTED.
- Not defined: CycleCount is tied to 0 and no counter flops are built.

## Structure
- Add to the definitions package: pc_state_t {IDLE, RUN, HALTED}, and the PC_W and CNT_W default constants.
- One sub-module, pc_next_calc: combinational next-PC computation (increment, forward/backward branch, soft-restart mux). It is kept separate so the branch arithmetic can be unit-tested.
- The top module holds the state register, the PC register, the latched StartAddr and the optional counter.

## Test plan
- Reset mid-RUN at PC=0x05A: Reset high -> PC=0, Running=0 and Done=0 asynchronously; after Start with StartAddr=0x010, PC=0x010 on the next edge.
- Start with StartAddr=0x000, no branches, 5 cycles -> PC goes 0,1,2,3,4,5; Running=1 throughout.
- At PC=0x020: Branch with offset 7, sign 0 -> PC=0x027; Branch with offset 7, sign 1 -> PC=0x019. At PC=0x002: offset 5, sign 1 -> PC=0x3FD (wrap).
- At PC=0x3FF with no branch -> PC=0x000. Branch with offset 0 at PC=0x030 -> PC stays 0x030 for 3 cycles.
- StartAddr=0x100, soft restart (AluReset=1, AluHalt=0) at PC=0x108 -> PC=0x100 and still Running. Halt (AluReset=1, AluHalt=1) at PC=0x104 -> Done=1 and PC=0x104; Start asserted in the same cycle is ignored.
- With CYCLE_COUNT_EN: Start, then halt on the 9th RUN edge -> CycleCount=9, held in HALTED and cleared by the next Start. Without CYCLE_COUNT_EN: CycleCount=0 throughout.
